pattern_gen: RTL and testbench

//  Stimulus-side counterpart of the analyzer's offset/mask trigger matcher: plays a

---
 rtl/pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_pattern_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Programmable pattern player: after a start-relative delay, plays words from a
// small register file onto data_out, optionally looping, with done on completion.
module pattern_gen #(
   parameter int DATA_W   = 33,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int OFFSET_W = 17
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [ADDR_W:0]     length,
   input  logic                loop,
   input  logic                start,
   output logic [DATA_W-1:0]   data_out,
   output logic                data_valid,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, DELAY, PLAY, DONE} state_t;

   state_t                state_q, state_d;
   logic [OFFSET_W-1:0]   count_q, count_d;
   logic [OFFSET_W-1:0]   off_q, off_d;
   logic [ADDR_W:0]       len_q, len_d;
   logic [ADDR_W:0]       idx_q, idx_d;
   logic                  loop_q, loop_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic                  wr_fire;
   logic [DATA_W-1:0]     word0;
   logic [ADDR_W:0]       len_clamp;
   logic                  do_emit;
   logic [ADDR_W:0]       emit_len;

   assign wr_fire   = wr_en && !busy_q;
   assign len_clamp = (length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : length;
   // A write landing on the run's first edge must be seen by word 0.
   assign word0     = (wr_fire && (wr_addr == '0)) ? wr_data : mem_q[0];

   always_ff @(posedge clock) begin
      if (wr_fire) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      off_d    = off_q;
      len_d    = len_q;
      idx_d    = idx_q;
      loop_d   = loop_q;
      data_d   = data_q;
      valid_d  = valid_q;
      done_d   = done_q;
      do_emit  = 1'b0;
      emit_len = len_q;

      if (!start) begin
         state_d = IDLE;
         count_d = '0;
         idx_d   = '0;
         data_d  = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               off_d   = offset;
               len_d   = len_clamp;
               loop_d  = loop;
               count_d = OFFSET_W'(1);
               if (offset == '0) begin
                  do_emit  = 1'b1;
                  emit_len = len_clamp;
               end else begin
                  state_d = DELAY;
               end
            end
            DELAY: begin
               count_d = count_q + 1'b1;
               if (count_q == off_q) begin
                  do_emit = 1'b1;
               end
            end
            PLAY: begin
               if (idx_q < len_q) begin
                  data_d = mem_q[idx_q[ADDR_W-1:0]];
                  idx_d  = idx_q + 1'b1;
               end else if (loop_q) begin
                  data_d = mem_q[0];
                  idx_d  = (ADDR_W+1)'(1);
               end else begin
                  data_d  = '0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase

         if (do_emit) begin
            if (emit_len == '0) begin
               data_d  = '0;
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               data_d  = word0;
               valid_d = 1'b1;
               idx_d   = (ADDR_W+1)'(1);
               state_d = PLAY;
            end
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         off_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         loop_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         off_q   <= off_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         loop_q  <= loop_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: randomized runs against a word-list model; expected words
// (value plus the cycle they must appear) are queued and checked by a monitor.
module tb_pattern_gen;
   localparam int DATA_W   = 33;
   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int OFFSET_W = 17;
   localparam int EW       = 32 + DATA_W;

   logic                clock = 1'b0;
   logic                reset;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [OFFSET_W-1:0] offset;
   logic [ADDR_W:0]     length;
   logic                loop;
   logic                start;
   logic [DATA_W-1:0]   data_out;
   logic                data_valid;
   logic                busy;
   logic                done;

   pattern_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .offset(offset), .length(length), .loop(loop), .start(start),
      .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [EW-1:0]     exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      return {1'($urandom_range(1, 0)), 32'($urandom)};
   endfunction

   // Monitor: every presented word must be the next queued one, at its cycle.
   logic [EW-1:0] mon_e;
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (data_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(data_out), 64'hDEAD);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word_data", 64'(data_out), 64'(mon_e[DATA_W-1:0]));
               chk("word_cycle", 64'(cyc), 64'(mon_e[EW-1:DATA_W]));
            end
         end else begin
            chk("idle_data_zero", 64'(data_out), 64'd0);
         end
      end
   end

   task automatic wait_n(input int n);
      repeat (n) begin
         @(negedge clock);
         wr_en = 1'b0;
      end
   endtask

   task automatic write_word(input int a, input logic [DATA_W-1:0] d, input bit taken);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = d;
      @(negedge clock);
      wr_en = 1'b0;
      if (taken) model_mem[a] = d;
   endtask

   // Word i of the pass appears after edge off+i; edge 0 is the next posedge.
   task automatic push_run(input int off, input int len, input bit lp, input int nwords);
      int n;
      int base;
      base = cyc;
      n = lp ? nwords : len;
      for (int i = 0; i < n; i++)
         exp_q.push_back({32'(base + off + i + 1), model_mem[i % len]});
   endtask

   task automatic run_once(input int off, input int len_in, input bit lp, input int nwords);
      int len;
      int d_edge;
      len    = (len_in > DEPTH) ? DEPTH : len_in;
      offset = OFFSET_W'(off);
      length = (ADDR_W+1)'(len_in);
      loop   = lp;
      start  = 1'b1;
      push_run(off, len, lp && len > 0, nwords);
      wait_n(1);
      chk("busy_after_start", 64'(busy), 64'd1);
      offset  = OFFSET_W'($urandom_range(0, 50));
      length  = (ADDR_W+1)'($urandom_range(0, 31));
      loop    = 1'($urandom_range(1, 0));
      // This write lands while busy and must be dropped.
      wr_en   = 1'b1;
      wr_addr = ADDR_W'($urandom_range(DEPTH - 1, 0));
      wr_data = rand_word();
      if (lp && len > 0) begin
         wait_n(off + nwords - 1);
         start = 1'b0;
         wait_n(1);
         chk("loop_stop_busy", 64'(busy), 64'd0);
         chk("loop_stop_valid", 64'(data_valid), 64'd0);
         chk("loop_stop_done", 64'(done), 64'd0);
      end else begin
         d_edge = off + len;
         wait_n(d_edge);
         chk("done_set", 64'(done), 64'd1);
         chk("done_valid_low", 64'(data_valid), 64'd0);
         wait_n(2);
         chk("done_held", 64'(done), 64'd1);
         chk("done_busy", 64'(busy), 64'd1);
         start = 1'b0;
         wait_n(1);
         chk("rearm_done", 64'(done), 64'd0);
         chk("rearm_busy", 64'(busy), 64'd0);
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] w;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      offset = '0; length = '0; loop = 1'b0; start = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_valid", 64'(data_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_data", 64'(data_out), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < DEPTH; i++) write_word(i, rand_word(), 1'b1);

      // Basic three-word run with offset 1.
      write_word(0, 33'd4, 1'b1);
      write_word(1, 33'd5, 1'b1);
      write_word(2, 33'd6, 1'b1);
      run_once(1, 3, 1'b0, 0);

      // Offset 0 continuous loop.
      run_once(0, 2, 1'b1, 9);

      // Abort at edge 50 of a 100-edge delay, then re-raise.
      offset = OFFSET_W'(100); length = 5'd4; loop = 1'b0; start = 1'b1;
      wait_n(50);
      start = 1'b0;
      wait_n(1);
      chk("abort_busy", 64'(busy), 64'd0);
      run_once(100, 4, 1'b0, 0);

      // Length boundaries.
      run_once(5, 0, 1'b0, 0);
      run_once(0, 0, 1'b0, 0);
      run_once(3, 20, 1'b0, 0);
      run_once(2, 16, 1'b1, 20);

      // Idle write of 7 becomes word 0 of the next run.
      write_word(0, 33'd7, 1'b1);
      run_once(0, 1, 1'b0, 0);

      // Write on the same edge that start is first sampled.
      w = rand_word();
      wr_en = 1'b1; wr_addr = '0; wr_data = w;
      model_mem[0] = w;
      run_once(0, 2, 1'b0, 0);

      // Randomized runs.
      for (int r = 0; r < 14; r++) begin
         for (int k = 0; k < 3; k++) write_word($urandom_range(DEPTH - 1, 0), rand_word(), 1'b1);
         run_once($urandom_range(0, 12), $urandom_range(0, 20), 1'($urandom_range(1, 0)),
                  $urandom_range(1, 25));
      end

      // Asynchronous reset mid-play; memory must survive.
      offset = '0; length = 5'd3; loop = 1'b1; start = 1'b1;
      push_run(0, 3, 1'b1, 2);
      wait_n(2);
      #1 reset = 1'b1; start = 1'b0;
      #1;
      chk("async_rst_valid", 64'(data_valid), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      chk("async_rst_data", 64'(data_out), 64'd0);
      wait_n(2);
      reset = 1'b0;
      wait_n(1);
      run_once(2, 3, 1'b0, 0);

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
